hazard_unit: RTL and testbench

Pipeline hazard controller for the 5-stage RV32I core. It is the producing end of the operand-forwarding path: it generates the 2-bit forward selects consumed by the Execute-stage operand muxes (00 = register file, 01 = ResultW, 10 = ALUResultM). It also generates the per-stage stall and flush controls for load-use hazards, taken branches/jumps and data-memory wait states. A small FSM tracks outstanding data-memory accesses, counts stall cycles and flags timeouts.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/forward_sel.sv | 33 +++
 rtl/hazard_unit.sv | 141 ++++++++++++++
 tb/tb_hazard_unit.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/forward_sel.sv
// Per-operand forward select: picks the youngest in-flight producer of RsE,
// Memory stage before Writeback, and never forwards x0.
module forward_sel
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] RsE,
  input  logic [REG_ADDR_WIDTH-1:0] RdM,
  input  logic [REG_ADDR_WIDTH-1:0] RdW,
  input  logic                      RegWriteM,
  input  logic                      RegWriteW,
  output fwd_sel_t                  Forward
);

  localparam logic [REG_ADDR_WIDTH-1:0] ZeroReg = REG_ADDR_WIDTH'(REG_ZERO);

  logic hitM;
  logic hitW;

  assign hitM = RegWriteM && (RdM != ZeroReg) && (RdM == RsE);
  assign hitW = RegWriteW && (RdW != ZeroReg) && (RdW == RsE);

  always_comb begin
    Forward = FWD_RF;
    if (hitM) begin
      Forward = FWD_M;
    end else if (hitW) begin
      Forward = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage RV32I core: operand forwarding selects,
// stall/flush generation and tracking of outstanding data-memory accesses.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32,
  parameter int MEM_TIMEOUT    = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
  input  logic [REG_ADDR_WIDTH-1:0] RdE,
  input  logic [REG_ADDR_WIDTH-1:0] RdM,
  input  logic [REG_ADDR_WIDTH-1:0] RdW,
  input  logic                      RegWriteM,
  input  logic                      RegWriteW,
  input  logic                      ResultSrcE0,
  input  logic                      PCSrcE,
  input  logic                      MemReqM,
  input  logic                      MemReadyM,
  output logic [1:0]                ForwardAE,
  output logic [1:0]                ForwardBE,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      StallE,
  output logic                      StallM,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic                      FlushW,
  output logic [CNT_WIDTH-1:0]      StallCount,
  output logic                      MemTimeout
);

  localparam int                    WAIT_W  = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0]     WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
  localparam logic [REG_ADDR_WIDTH-1:0] ZeroReg = REG_ADDR_WIDTH'(REG_ZERO);

  fwd_sel_t fwdA;
  fwd_sel_t fwdB;

  forward_sel #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
    .RsE       (Rs1E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .Forward   (fwdA)
  );

  forward_sel #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
    .RsE       (Rs2E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .Forward   (fwdB)
  );

  assign ForwardAE = fwdA;
  assign ForwardBE = fwdB;

  logic lwStall;
  logic memStall;

  assign lwStall  = ResultSrcE0 && (RdE != ZeroReg) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign memStall = MemReqM && !MemReadyM;

  // A memory stall freezes the whole pipe, so flushes and load-use bubbles
  // are held back until it clears.
  assign StallF = lwStall || memStall;
  assign StallD = lwStall || memStall;
  assign StallE = memStall;
  assign StallM = memStall;
  assign FlushW = memStall;
  assign FlushD = PCSrcE && !memStall;
  assign FlushE = (lwStall || PCSrcE) && !memStall;

  mem_state_t           state_q,      state_d;
  logic [WAIT_W-1:0]    waitCnt_q,    waitCnt_d;
  logic                 memTimeout_q, memTimeout_d;
  logic [CNT_WIDTH-1:0] stallCount_q, stallCount_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      waitCnt_q    <= '0;
      memTimeout_q <= 1'b0;
      stallCount_q <= '0;
    end else begin
      state_q      <= state_d;
      waitCnt_q    <= waitCnt_d;
      memTimeout_q <= memTimeout_d;
      stallCount_q <= stallCount_d;
    end
  end

  // The FSM never forces a release on timeout; it only raises the sticky flag.
  always_comb begin
    state_d      = state_q;
    waitCnt_d    = waitCnt_q;
    memTimeout_d = memTimeout_q;
    unique case (state_q)
      IDLE: begin
        waitCnt_d = '0;
        if (memStall) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (waitCnt_q != WAIT_MAX) begin
          waitCnt_d = waitCnt_q + WAIT_W'(1);
        end
        if (MemReadyM || !MemReqM) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        waitCnt_d = '0;
      end
    endcase
    if (waitCnt_d == WAIT_MAX) begin
      memTimeout_d = 1'b1;
    end
  end

  always_comb begin
    stallCount_d = stallCount_q;
    if (StallF && (stallCount_q != '1)) begin
      stallCount_d = stallCount_q + CNT_WIDTH'(1);
    end
  end

  assign StallCount = stallCount_q;
  assign MemTimeout = memTimeout_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized
// traffic compared against a rule-level reference model.
module tb_hazard_unit;

  localparam int RW = 5;
  localparam int CW = 8;
  localparam int TO = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [RW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic          RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [CW-1:0] StallCount;
  logic          MemTimeout;

  int checks = 0;
  int errors = 0;

  hazard_unit #(.REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW), .MEM_TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Rs1D        (Rs1D),
    .Rs2D        (Rs2D),
    .Rs1E        (Rs1E),
    .Rs2E        (Rs2E),
    .RdE         (RdE),
    .RdM         (RdM),
    .RdW         (RdW),
    .RegWriteM   (RegWriteM),
    .RegWriteW   (RegWriteW),
    .ResultSrcE0 (ResultSrcE0),
    .PCSrcE      (PCSrcE),
    .MemReqM     (MemReqM),
    .MemReadyM   (MemReadyM),
    .ForwardAE   (ForwardAE),
    .ForwardBE   (ForwardBE),
    .StallF      (StallF),
    .StallD      (StallD),
    .StallE      (StallE),
    .StallM      (StallM),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .FlushW      (FlushW),
    .StallCount  (StallCount),
    .MemTimeout  (MemTimeout)
  );

  always #5 clk = ~clk;

  // Reference model: memory access tracked as "currently waiting" plus the
  // number of cycles spent waiting in this access.
  bit mWaiting;
  int mWaitCycles;
  int mStallCount;
  bit mTimeout;

  function automatic logic [1:0] refFwd(input logic [RW-1:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit refLw();
    return ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
  endfunction

  function automatic bit refMem();
    return MemReqM && !MemReadyM;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mWaiting    = 0;
      mWaitCycles = 0;
      mStallCount = 0;
      mTimeout    = 0;
    end else begin
      if ((refLw() || refMem()) && mStallCount < CNT_MAX) mStallCount++;
      if (mWaiting) begin
        mWaitCycles++;
        if (mWaitCycles >= TO) mTimeout = 1;
        if (MemReadyM || !MemReqM) mWaiting = 0;
      end else begin
        mWaitCycles = 0;
        if (refMem()) mWaiting = 1;
      end
    end
  end

  task automatic idleInputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
    RdE = '0; RdM = '0; RdW = '0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE0 = 0;
    PCSrcE = 0; MemReqM = 0; MemReadyM = 0;
  endtask

  task automatic doReset();
    @(negedge clk);
    idleInputs();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idleInputs();
    #12;
    if (StallCount !== '0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", StallCount); end
    checks++;
    if (MemTimeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout got %b want 0", MemTimeout); end
    checks++;
    if ({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW} !== 7'b0) begin
      errors++; $display("[TB] FAIL reset_ctrl got %b want 0", {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW});
    end
    checks++;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    idleInputs();
    RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 5;
    #1;
    if (ForwardAE !== 2'b10) begin errors++; $display("[TB] FAIL fwdA_mprio got %b want 10", ForwardAE); end
    checks++;
    if (ForwardBE !== 2'b10) begin errors++; $display("[TB] FAIL fwdB_mprio got %b want 10", ForwardBE); end
    checks++;
    RegWriteM = 0; Rs2E = 6;
    #1;
    if (ForwardAE !== 2'b01) begin errors++; $display("[TB] FAIL fwdA_w got %b want 01", ForwardAE); end
    checks++;
    if (ForwardBE !== 2'b00) begin errors++; $display("[TB] FAIL fwdB_nohit got %b want 00", ForwardBE); end
    checks++;
    RegWriteM = 1; RdM = 0; RdW = 0; Rs1E = 0; Rs2E = 0;
    #1;
    if (ForwardAE !== 2'b00) begin errors++; $display("[TB] FAIL fwdA_x0 got %b want 00", ForwardAE); end
    checks++;
    if (ForwardBE !== 2'b00) begin errors++; $display("[TB] FAIL fwdB_x0 got %b want 00", ForwardBE); end
    checks++;
    RdM = 9; Rs1E = 3; Rs2E = 9; RdW = 3;
    #1;
    if ({ForwardAE, ForwardBE} !== 4'b0110) begin errors++; $display("[TB] FAIL fwd_split got %b want 0110", {ForwardAE, ForwardBE}); end
    checks++;
  endtask

  task automatic test_load_use();
    @(negedge clk);
    idleInputs();
    ResultSrcE0 = 1; RdE = 7; Rs2D = 7; Rs1D = 2;
    #1;
    if ({StallF, StallD, FlushE, StallE, StallM, FlushD} !== 6'b111000) begin
      errors++; $display("[TB] FAIL load_use got %b want 111000", {StallF, StallD, FlushE, StallE, StallM, FlushD});
    end
    checks++;
    RdE = 0; Rs2D = 0;
    #1;
    if ({StallF, StallD, FlushE, StallE} !== 4'b0000) begin
      errors++; $display("[TB] FAIL load_use_x0 got %b want 0000", {StallF, StallD, FlushE, StallE});
    end
    checks++;
    RdE = 4; Rs1D = 4; PCSrcE = 1;
    #1;
    if ({StallD, FlushD, FlushE, StallE} !== 4'b1110) begin
      errors++; $display("[TB] FAIL load_use_branch got %b want 1110", {StallD, FlushD, FlushE, StallE});
    end
    checks++;
  endtask

  task automatic test_branch_flush();
    @(negedge clk);
    idleInputs();
    PCSrcE = 1;
    #1;
    if ({FlushD, FlushE, StallF, StallD, StallE, StallM, FlushW} !== 7'b1100000) begin
      errors++; $display("[TB] FAIL branch got %b want 1100000", {FlushD, FlushE, StallF, StallD, StallE, StallM, FlushW});
    end
    checks++;
    MemReqM = 1; MemReadyM = 0; ResultSrcE0 = 1; RdE = 3; Rs1D = 3;
    #1;
    if ({FlushD, FlushE, StallF, StallD, StallE, StallM, FlushW} !== 7'b0011111) begin
      errors++; $display("[TB] FAIL branch_memstall got %b want 0011111", {FlushD, FlushE, StallF, StallD, StallE, StallM, FlushW});
    end
    checks++;
    @(negedge clk);
    idleInputs();
  endtask

  task automatic test_mem_wait();
    doReset();
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      idleInputs();
      MemReqM = (i <= 4);
      MemReadyM = (i == 4);
      #1;
      if ({StallF, StallE, FlushW} !== {3{i <= 3}}) begin
        errors++; $display("[TB] FAIL memwait_stall cyc %0d got %b want %b", i, {StallF, StallE, FlushW}, {3{i <= 3}});
      end
      checks++;
    end
    if (StallCount !== CW'(3)) begin errors++; $display("[TB] FAIL memwait_count got %0d want 3", StallCount); end
    checks++;
    if (MemTimeout !== 1'b0) begin errors++; $display("[TB] FAIL memwait_timeout got %b want 0", MemTimeout); end
    checks++;
  endtask

  task automatic test_timeout();
    doReset();
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      idleInputs();
      MemReqM = (i <= 7);
      MemReadyM = (i == 7);
      #1;
      if (MemTimeout !== (i >= 6)) begin
        errors++; $display("[TB] FAIL timeout cyc %0d got %b want %b", i, MemTimeout, (i >= 6));
      end
      checks++;
    end
    if (StallCount !== CW'(6)) begin errors++; $display("[TB] FAIL timeout_count got %0d want 6", StallCount); end
    checks++;
  endtask

  task automatic test_async_reset();
    doReset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      MemReqM = 1; MemReadyM = 0;
    end
    #1;
    if (MemTimeout !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_timeout got %b want 1", MemTimeout); end
    checks++;
    #1;
    rst_n = 0;
    #1;
    if (StallCount !== '0) begin errors++; $display("[TB] FAIL async_count got %0d want 0", StallCount); end
    checks++;
    if (MemTimeout !== 1'b0) begin errors++; $display("[TB] FAIL async_timeout got %b want 0", MemTimeout); end
    checks++;
    @(negedge clk);
    idleInputs();
    rst_n = 1;
    @(negedge clk);
    #1;
    if ({StallF, StallD, StallE, StallM} !== 4'b0) begin
      errors++; $display("[TB] FAIL post_reset_stall got %b want 0000", {StallF, StallD, StallE, StallM});
    end
    checks++;
    if (StallCount !== '0) begin errors++; $display("[TB] FAIL post_reset_count got %0d want 0", StallCount); end
    checks++;
  endtask

  task automatic test_stall_saturate();
    doReset();
    @(negedge clk);
    ResultSrcE0 = 1; RdE = 3; Rs1D = 3;
    repeat (CNT_MAX + 10) @(negedge clk);
    #1;
    if (StallCount !== CW'(CNT_MAX)) begin errors++; $display("[TB] FAIL count_saturate got %0d want %0d", StallCount, CNT_MAX); end
    checks++;
    if (MemTimeout !== 1'b0) begin errors++; $display("[TB] FAIL lw_no_timeout got %b want 0", MemTimeout); end
    checks++;
    idleInputs();
  endtask

  task automatic test_random();
    bit lw, mem;
    doReset();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      Rs1D = RW'($urandom_range(0, 3)); Rs2D = RW'($urandom_range(0, 3));
      Rs1E = RW'($urandom_range(0, 3)); Rs2E = RW'($urandom_range(0, 3));
      RdE  = RW'($urandom_range(0, 3)); RdM  = RW'($urandom_range(0, 3));
      RdW  = RW'($urandom_range(0, 3));
      RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      ResultSrcE0 = ($urandom_range(0, 3) == 0);
      PCSrcE = ($urandom_range(0, 4) == 0);
      MemReqM = ($urandom_range(0, 2) == 0);
      MemReadyM = ($urandom_range(0, 9) < 6);
      #1;
      lw = refLw();
      mem = refMem();
      if (ForwardAE !== refFwd(Rs1E) || ForwardBE !== refFwd(Rs2E)) begin
        errors++; $display("[TB] FAIL rand_fwd cyc %0d got %b%b want %b%b", i, ForwardAE, ForwardBE, refFwd(Rs1E), refFwd(Rs2E));
      end
      checks++;
      if ({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW} !==
          {lw | mem, lw | mem, mem, mem, PCSrcE & !mem, (lw | PCSrcE) & !mem, mem}) begin
        errors++; $display("[TB] FAIL rand_ctrl cyc %0d got %b want %b", i,
          {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW},
          {lw | mem, lw | mem, mem, mem, PCSrcE & !mem, (lw | PCSrcE) & !mem, mem});
      end
      checks++;
      if (StallCount !== CW'(mStallCount) || MemTimeout !== mTimeout) begin
        errors++; $display("[TB] FAIL rand_state cyc %0d got %0d/%b want %0d/%b", i, StallCount, MemTimeout, mStallCount, mTimeout);
      end
      checks++;
    end
    idleInputs();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_flush();
    test_mem_wait();
    test_timeout();
    test_async_reset();
    test_stall_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
